// File: rtl/sipo_shift_register.sv
// sipo_shift_register: serial-in, parallel-out deserializer.
// Collects WIDTH serial bits on enabled clock edges. Each completed word is
// presented on a held parallel output together with a one-cycle valid strobe.
// Optional feature macro: SIPO_LIVE_OUT_EN. When it is defined, parallel_out
// follows the shift register on every shift, and the held output register is
// removed. When it is undefined (the default), parallel_out holds the last
// completed word.
module sipo_shift_register #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic             data_valid
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             data_valid_q, data_valid_d;
   logic [WIDTH-1:0] shifted;

   // Shifted value with the current serial bit inserted on the configured end
   always_comb begin
      shifted = shreg_q;
      if (MSB_FIRST) begin
         shifted = {shreg_q[WIDTH-2:0], serial_in};
      end else begin
         shifted = {serial_in, shreg_q[WIDTH-1:1]};
      end
   end

   // Next-state for shift register, bit counter and valid strobe
   always_comb begin
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      data_valid_d = 1'b0;
      if (shift_en) begin
         shreg_d = shifted;
         if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            data_valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // Core state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg_q      <= '0;
         cnt_q        <= '0;
         data_valid_q <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign data_valid = data_valid_q;

`ifdef SIPO_LIVE_OUT_EN
   // Live mode: the shift register itself is the parallel output
   assign parallel_out = shreg_q;
`else
   logic [WIDTH-1:0] parallel_out_q, parallel_out_d;

   // Output word loads only when a frame completes
   always_comb begin
      parallel_out_d = parallel_out_q;
      if (shift_en && (cnt_q == CNT_LAST)) begin
         parallel_out_d = shifted;
      end
   end

   // Held completed-word register
   always_ff @(posedge clk) begin
      if (!rst) begin
         parallel_out_q <= '0;
      end else begin
         parallel_out_q <= parallel_out_d;
      end
   end

   assign parallel_out = parallel_out_q;
`endif

endmodule

// File: tb/tb_sipo_shift_register.sv
// Testbench for sipo_shift_register. Two instances share the same stimulus:
// one is MSB-first and one is LSB-first. Both are compared each cycle against
// a bit-history reference model. The bench then runs directed frames and a
// randomized phase.
module tb_sipo_shift_register;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         shift_en;
   logic         serial_in;
   logic [W-1:0] parallelOutMsb;
   logic         dataValidMsb;
   logic [W-1:0] parallelOutLsb;
   logic         dataValidLsb;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state: bits of the current frame, recent bit history
   // since reset, the last completed words and the expected strobe
   int           frameBits[$];
   int           histBits[$];
   logic [W-1:0] expWordMsb;
   logic [W-1:0] expWordLsb;
   logic         expValid;

   sipo_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
      .clk          (clk),
      .rst          (rst),
      .shift_en     (shift_en),
      .serial_in    (serial_in),
      .parallel_out (parallelOutMsb),
      .data_valid   (dataValidMsb)
   );

   sipo_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
      .clk          (clk),
      .rst          (rst),
      .shift_en     (shift_en),
      .serial_in    (serial_in),
      .parallel_out (parallelOutLsb),
      .data_valid   (dataValidLsb)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Expected parallel outputs, derived from the model history
   function automatic logic [W-1:0] modelOut(input bit msbFirst);
      logic [W-1:0] v;
      v = '0;
`ifdef SIPO_LIVE_OUT_EN
      // Live output: the most recent W bits received since reset
      for (int i = 0; i < histBits.size(); i++) begin
         if (msbFirst) v[W-1-(histBits.size()-1-i)] = 1'b0;
      end
      for (int k = 0; k < histBits.size(); k++) begin
         // Age 0 is the newest bit
         int age;
         age = histBits.size() - 1 - k;
         if (msbFirst) v[age] = histBits[k][0];
         else          v[W-1-age] = histBits[k][0];
      end
`else
      v = msbFirst ? expWordMsb : expWordLsb;
`endif
      return v;
   endfunction

   // Apply one clock edge of stimulus, advance the model, then check both DUTs
   task automatic applyStimulus(input logic r, input logic e, input logic s);
      rst       = r;
      shift_en  = e;
      serial_in = s;
      @(posedge clk);
      if (!r) begin
         frameBits.delete();
         histBits.delete();
         expWordMsb = '0;
         expWordLsb = '0;
         expValid   = 1'b0;
      end else if (e) begin
         frameBits.push_back(int'(s));
         histBits.push_back(int'(s));
         if (histBits.size() > W) void'(histBits.pop_front());
         if (frameBits.size() == W) begin
            expWordMsb = '0;
            expWordLsb = '0;
            for (int i = 0; i < W; i++) begin
               expWordMsb[W-1-i] = frameBits[i][0];
               expWordLsb[i]     = frameBits[i][0];
            end
            frameBits.delete();
            expValid = 1'b1;
         end else begin
            expValid = 1'b0;
         end
      end else begin
         expValid = 1'b0;
      end
      #1;
      checkOutput("msb_out",   32'(parallelOutMsb), 32'(modelOut(1'b1)));
      checkOutput("msb_valid", 32'(dataValidMsb),   32'(expValid));
      checkOutput("lsb_out",   32'(parallelOutLsb), 32'(modelOut(1'b0)));
      checkOutput("lsb_valid", 32'(dataValidLsb),   32'(expValid));
   endtask

   // Shift a byte in the order MSB down to LSB
   task automatic sendByte(input logic [7:0] value);
      for (int i = 7; i >= 0; i--) applyStimulus(1'b1, 1'b1, value[i]);
   endtask

   // Directed plan followed by randomized traffic
   initial begin
      rst        = 1'b0;
      shift_en   = 1'b0;
      serial_in  = 1'b0;
      expWordMsb = '0;
      expWordLsb = '0;
      expValid   = 1'b0;

      $display("[TB] reset held with shift_en=1, serial_in=1");
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("reset_out",   32'(parallelOutMsb), 32'h0);
      checkOutput("reset_valid", 32'(dataValidMsb),   32'h0);

      $display("[TB] single frame 0xAA");
      sendByte(8'hAA);
      checkOutput("frame_aa", 32'(parallelOutMsb), 32'hAA);
      checkOutput("frame_aa_lsb", 32'(parallelOutLsb), 32'h55);

      $display("[TB] back-to-back frame 0xCC");
      sendByte(8'hCC);
      checkOutput("frame_cc", 32'(parallelOutMsb), 32'hCC);

      $display("[TB] enable gap inside frame 0xF0");
      for (int i = 7; i >= 4; i--) applyStimulus(1'b1, 1'b1, 1'(8'hF0 >> i));
      for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) applyStimulus(1'b1, 1'b1, 1'(8'hF0 >> i));
      checkOutput("frame_f0", 32'(parallelOutMsb), 32'hF0);

      $display("[TB] reset mid-frame then 0x3C");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      sendByte(8'h3C);
      checkOutput("frame_3c", 32'(parallelOutMsb), 32'h3C);

      $display("[TB] LSB-first bit order");
      sendByte(8'h80);
      checkOutput("lsb_first_01", 32'(parallelOutLsb), 32'h01);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 39) != 0),
                       ($urandom_range(0, 9) < 7),
                       1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/sipo_shift_register.md
# sipo_shift_register

Serial-in, parallel-out deserializer. Collects `WIDTH` serial bits, sampled on enabled clock edges, into a word. Presents each completed word on a held parallel output with a one-cycle valid strobe. Sits behind a serial receive front-end and feeds word-wide datapath logic.

## Interface
- `WIDTH`, default 8: word length in bits; legal values are 2 or more.
- `MSB_FIRST`, default 1: when 1, the first received bit lands in `parallel_out[WIDTH-1]`; when 0, it lands in bit 0.
- `clk` input, 1 bit: the single clock. All logic is rising-edge triggered.
- `rst` input, 1 bit: reset, synchronous and active-low. Sampled on the `clk` rising edge.
- `shift_en` input, 1 bit: when high, `serial_in` is sampled on this edge.
- `serial_in` input, 1 bit: serial data bit.
- `parallel_out` output, `WIDTH` bits: the last completed word, registered.
- `data_valid` output, 1 bit: one-cycle strobe marking a new word on `parallel_out`.

## Operation
- Internal state:
  - `WIDTH`-bit shift register `shreg`.
  - Bit counter `cnt`, range 0..`WIDTH`-1, width clog2(`WIDTH`).
  - Output register `parallel_out`.
  - Registered `data_valid`.
- Reset (`rst`=0 at an edge) clears `shreg`, `cnt`, `parallel_out` and `data_valid` to 0. Reset wins over every other input.
- Reset arriving mid-frame discards the partial frame. The next enabled bit is bit 0 of a new frame.
- Shifting with `MSB_FIRST`=1: `shreg <= {shreg[WIDTH-2:0], serial_in}` (left shift, new bit at the LSB).
- Shifting with `MSB_FIRST`=0: `shreg <= {serial_in, shreg[WIDTH-1:1]}` (right shift, new bit at the MSB).
- On an edge with `shift_en`=1 and `cnt` < `WIDTH`-1:
  - Shift `shreg`.
  - `cnt` increments.
  - `data_valid` goes to 0.
- On an edge with `shift_en`=1 and `cnt` = `WIDTH`-1 (frame completes):
  - `parallel_out` loads the shifted value, including the current bit.
  - `shreg` loads the same shifted value.
  - `cnt` wraps to 0.
  - `data_valid` goes to 1.
- On an edge with `shift_en`=0:
  - `shreg`, `cnt` and `parallel_out` hold.
  - `data_valid` goes to 0.
  - The partial frame is paused, not aborted.
- `parallel_out` changes only on frame completion or reset. It holds between frames.
- Back-to-back frames need no idle cycle. The bit after completion is bit 0 of the next frame.

## Timing
- One bit is accepted per enabled edge. A full frame takes `WIDTH` enabled edges; disabled edges in between are allowed.
- Latency: `parallel_out` and `data_valid` update at the same edge that samples the final bit. They are visible in the cycle after that edge.
- `data_valid` is high for exactly one cycle per completed frame. It is never high two cycles in a row unless two frames complete on consecutive edges, which is impossible for `WIDTH` ≥ 2.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- Macro `SIPO_LIVE_OUT_EN`.
- Defined: `parallel_out` is driven directly from `shreg` and follows every shift. `data_valid` behaviour is unchanged. The separate output register is removed.
- Undefined (default): `parallel_out` is the held completed-word register described above.

## Test plan
- Reset:
  - Stimulus: drive `rst`=0 for 2 edges with `shift_en`=1 and `serial_in`=1, then release.
  - Required: `parallel_out`=0x00 and `data_valid`=0 throughout reset; `cnt` restarts at 0 after release.
- Single frame, `MSB_FIRST`=1:
  - Stimulus: shift 1,0,1,0,1,0,1,0 on 8 consecutive enabled edges.
  - Required: `parallel_out`=0xAA and `data_valid` pulses once in the cycle after the 8th edge.
  - Required: `parallel_out` is unchanged (0x00) during bits 1-7.
- Back-to-back frames:
  - Stimulus: shift 0xAA bits immediately followed by 1,1,0,0,1,1,0,0.
  - Required: 0xAA, then 0xCC exactly 8 cycles later, with two single-cycle `data_valid` pulses.
- Enable gaps:
  - Stimulus: shift 4 bits of 0xF0, deassert `shift_en` for 3 cycles, then shift the remaining 4 bits.
  - Required: `parallel_out`=0xF0 with one `data_valid` pulse; no pulse occurs during the gap.
- Reset mid-frame:
  - Stimulus: shift 5 bits, assert `rst` for 1 edge, then shift 8 bits of 0x3C.
  - Required: `parallel_out`=0x3C; no valid pulse for the aborted frame.
- `MSB_FIRST`=0:
  - Stimulus: shift 1,0,0,0,0,0,0,0.
  - Required: `parallel_out`=0x01.
